// File: rtl/ymc_control.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory handshake stall, retired count.
// Optional YMC_TRAP_EN: unknown opcodes halt the machine and raise a sticky trap flag.
module ymc_control #(
  parameter int CNTW    = 16,
  parameter int OPW     = 3,
  parameter int MAXWAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ins,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic [1:0]      PCSrc,
  output logic            RegWrite,
  output logic            ALUSrc,
  output logic [OPW-1:0]  op,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Mem2Reg,
  output logic            halted,
  output logic            timeout,
  output logic [CNTW-1:0] retired,
  output logic [2:0]      dbg_state
`ifdef YMC_TRAP_EN
  ,
  output logic            trap
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(3'b010);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3'b110);
  localparam logic [OPW-1:0] OP_AND = OPW'(3'b000);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3'b001);
  localparam logic [OPW-1:0] OP_SLT = OPW'(3'b111);

  localparam int WW = (MAXWAIT > 1) ? $clog2(MAXWAIT) : 1;
  localparam logic [WW-1:0] WLAST = WW'((MAXWAIT > 0) ? MAXWAIT - 1 : 0);

  state_t        state;
  logic [6:0]    opc;
  logic [2:0]    f3;
  logic          f7b;
  logic [WW-1:0] wcnt;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_halt, is_unk;

  // Class decode works on the fields latched in FETCH, never on the live ins bus.
  // Every 0x63 opcode is treated as beq.
  always_comb begin
    is_r    = (opc == 7'h33);
    is_i    = (opc == 7'h13);
    is_ld   = (opc == 7'h03);
    is_st   = (opc == 7'h23);
    is_br   = (opc == 7'h63);
    is_jal  = (opc == 7'h6F);
    is_halt = (opc == 7'h73);
    is_unk  = !(is_r || is_i || is_ld || is_st || is_br || is_jal || is_halt);
  end

  function automatic logic [OPW-1:0] alu_map(input logic [2:0] fn3, input logic sub_sel);
    case (fn3)
      3'd0:    alu_map = sub_sel ? OP_SUB : OP_ADD;
      3'd7:    alu_map = OP_AND;
      3'd6:    alu_map = OP_OR;
      3'd2:    alu_map = OP_SLT;
      default: alu_map = OP_ADD;
    endcase
  endfunction

  logic [OPW-1:0] class_op;
  logic           class_src;

  always_comb begin
    class_op  = OP_ADD;
    class_src = 1'b0;
    if (is_r) begin
      class_op = alu_map(f3, f7b);
    end else if (is_i) begin
      class_op  = alu_map(f3, 1'b0);
      class_src = 1'b1;
    end else if (is_ld || is_st) begin
      class_src = 1'b1;
    end else if (is_br) begin
      class_op = OP_SUB;
    end
  end

  // Outputs are decoded from state; reset forces them idle at once so no strobe leaks
  // out while the asynchronous reset is asserted.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 2'd0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    op       = OP_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    halted   = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: IRWrite = 1'b1;
        S_EXEC: begin
          if (is_r || is_i || is_ld || is_st || is_br) begin
            ALUSrc = class_src;
            op     = class_op;
          end
          if (is_br) begin
            PCWrite = 1'b1;
            PCSrc   = zero ? 2'd1 : 2'd0;
          end else if (is_jal) begin
            PCWrite = 1'b1;
            PCSrc   = 2'd2;
          end else if (is_unk) begin
            PCWrite = 1'b1;
          end
        end
        S_MEM: begin
          ALUSrc   = 1'b1;
          op       = OP_ADD;
          MemRead  = is_ld;
          MemWrite = is_st;
          PCWrite  = is_st && mem_ready;
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          ALUSrc   = class_src;
          op       = class_op;
          Mem2Reg  = is_ld;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      retired <= '0;
      timeout <= 1'b0;
      wcnt    <= '0;
      opc     <= '0;
      f3      <= '0;
      f7b     <= 1'b0;
`ifdef YMC_TRAP_EN
      trap    <= 1'b0;
`endif
    end else begin
      if (PCWrite) retired <= retired + CNTW'(1);
      case (state)
        S_FETCH: begin
          opc   <= ins[6:0];
          f3    <= ins[14:12];
          f7b   <= ins[30];
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (is_halt) begin
            state <= S_HALT;
`ifdef YMC_TRAP_EN
          end else if (is_unk) begin
            trap  <= 1'b1;
            state <= S_HALT;
`endif
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_r || is_i)        state <= S_WB;
          else if (is_ld || is_st) state <= S_MEM;
          else                     state <= S_FETCH;
        end
        S_MEM: begin
          if (mem_ready) begin
            wcnt  <= '0;
            state <= is_ld ? S_WB : S_FETCH;
          end else if ((MAXWAIT > 0) && (wcnt == WLAST)) begin
            wcnt    <= '0;
            timeout <= 1'b1;
            state   <= S_HALT;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ymc_control.sv
// Directed bench for ymc_control: per-cycle strobe vectors go through an expected queue
// and are compared at the falling edge; retired/timeout/halt/trap checked at step boundaries.
module tb_ymc_control;

  localparam int CNTW = 16;
  localparam int OPW  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     ins;
  logic            zero;
  logic            mem_ready;
  logic            IRWrite, PCWrite, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
  logic            halted, timeout;
  logic [1:0]      PCSrc;
  logic [OPW-1:0]  op;
  logic [CNTW-1:0] retired;
  logic [2:0]      dbg_state;
`ifdef YMC_TRAP_EN
  logic            trap;
`endif

  ymc_control #(.CNTW(CNTW), .OPW(OPW), .MAXWAIT(4)) dut (
    .clk(clk), .reset(reset), .ins(ins), .zero(zero), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .op(op), .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem2Reg(Mem2Reg), .halted(halted), .timeout(timeout), .retired(retired),
    .dbg_state(dbg_state)
`ifdef YMC_TRAP_EN
    , .trap(trap)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  logic [13:0] exp_q[$];

  function automatic logic [13:0] v(input logic irw, input logic pcw, input logic [1:0] src,
                                    input logic rw, input logic as, input logic [2:0] o,
                                    input logic mr, input logic mw, input logic m2r,
                                    input logic h, input logic t);
    return {irw, pcw, src, rw, as, o, mr, mw, m2r, h, t};
  endfunction

  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000, OR_ = 3'b001, SLT = 3'b111;

  logic [13:0] idle_v, fet_v, got, exp_v;
  initial begin
    idle_v = v(0, 0, 2'd0, 0, 0, ADD, 0, 0, 0, 0, 0);
    fet_v  = v(1, 0, 2'd0, 0, 0, ADD, 0, 0, 0, 0, 0);
  end

  // One clock cycle: push the expected strobe vector, compare at the falling edge,
  // then return 1 time unit after the next rising edge so the caller can drive inputs.
  task automatic cyc(input logic [13:0] e, input string tag);
    exp_q.push_back(e);
    @(negedge clk);
    got = {IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg,
           halted, timeout};
    exp_v = exp_q.pop_front();
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
    checks++;
    assert (retired === CNTW'(exp_ret)) else begin
      errors++;
      $error("FAIL %s: retired observed %0d expected %0d", tag, retired, exp_ret);
    end
  endtask

  task automatic chk_bit(input logic obs, input logic e, input string tag);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  // driver tasks
  task automatic front(input logic [31:0] i);
    ins = i;
    cyc(fet_v, "fetch");
    ins = $urandom();  // ins only matters in FETCH
    cyc(idle_v, "decode");
  endtask

  task automatic run_alu(input logic [31:0] i, input logic [2:0] o, input logic as, input string tag);
    front(i);
    cyc(v(0, 0, 2'd0, 0, as, o, 0, 0, 0, 0, 0), tag);
    cyc(v(0, 1, 2'd0, 1, as, o, 0, 0, 0, 0, 0), tag);
    exp_ret++;
    chk_ret(tag);
  endtask

  task automatic run_load(input int waits);
    front(32'h0000A103);
    cyc(v(0, 0, 2'd0, 0, 1, ADD, 0, 0, 0, 0, 0), "lw_exec");
    for (int k = 0; k <= waits; k++) begin
      mem_ready = (k == waits);
      cyc(v(0, 0, 2'd0, 0, 1, ADD, 1, 0, 0, 0, 0), "lw_mem");
    end
    mem_ready = 1'b0;
    cyc(v(0, 1, 2'd0, 1, 1, ADD, 0, 0, 1, 0, 0), "lw_wb");
    exp_ret++;
    chk_ret("lw_ret");
  endtask

  task automatic run_store(input int waits);
    front(32'h0020A023);
    cyc(v(0, 0, 2'd0, 0, 1, ADD, 0, 0, 0, 0, 0), "sw_exec");
    for (int k = 0; k < waits; k++) begin
      mem_ready = 1'b0;
      cyc(v(0, 0, 2'd0, 0, 1, ADD, 0, 1, 0, 0, 0), "sw_wait");
    end
    mem_ready = 1'b1;
    cyc(v(0, 1, 2'd0, 0, 1, ADD, 0, 1, 0, 0, 0), "sw_done");
    mem_ready = 1'b0;
    exp_ret++;
    chk_ret("sw_ret");
  endtask

  task automatic run_branch(input logic z);
    front(32'h00208063);
    zero = z;
    cyc(v(0, 1, z ? 2'd1 : 2'd0, 0, 0, SUB, 0, 0, 0, 0, 0), z ? "beq_taken" : "beq_not");
    zero = 1'b0;
    exp_ret++;
    chk_ret("beq_ret");
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cyc(idle_v, tag);
    exp_ret = 0;
    chk_ret(tag);
    checks++;
    assert (dbg_state === 3'd0) else begin
      errors++;
      $error("FAIL %s_state: observed %0d expected 0", tag, dbg_state);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ins = 32'h0;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    run_alu(32'h002081B3, ADD, 1'b0, "add");
    run_alu(32'h402081B3, SUB, 1'b0, "sub");
    run_alu(32'h0020A1B3, SLT, 1'b0, "slt");
    run_alu(32'h0020F1B3, AND_, 1'b0, "and");
    run_alu(32'h0020E1B3, OR_, 1'b0, "or");
    run_alu(32'h002091B3, ADD, 1'b0, "sll_as_add");
    run_alu(32'h40008093, ADD, 1'b1, "addi_bit30");
    run_alu(32'h0020A093, SLT, 1'b1, "slti");

    run_load(3);
    run_load(0);
    run_store(0);
    run_store(2);
    run_branch(1'b1);
    run_branch(1'b0);

    front(32'h0000006F);
    cyc(v(0, 1, 2'd2, 0, 0, ADD, 0, 0, 0, 0, 0), "jal");
    exp_ret++;
    chk_ret("jal_ret");

`ifdef YMC_TRAP_EN
    front(32'h0000007F);
    cyc(v(0, 0, 2'd0, 0, 0, ADD, 0, 0, 0, 1, 0), "trap_halt");
    chk_ret("trap_ret");
    chk_bit(trap, 1'b1, "trap_set");
    cyc(v(0, 0, 2'd0, 0, 0, ADD, 0, 0, 0, 1, 0), "trap_stay");
    do_reset("trap_reset");
    chk_bit(trap, 1'b0, "trap_clear");
`else
    front(32'h0000007F);
    cyc(v(0, 1, 2'd0, 0, 0, ADD, 0, 0, 0, 0, 0), "nop");
    exp_ret++;
    chk_ret("nop_ret");
`endif

    // store with memory never ready: four MEM cycles then timeout halt
    front(32'h0020A023);
    cyc(v(0, 0, 2'd0, 0, 1, ADD, 0, 0, 0, 0, 0), "to_exec");
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) cyc(v(0, 0, 2'd0, 0, 1, ADD, 0, 1, 0, 0, 0), "to_mem");
    cyc(v(0, 0, 2'd0, 0, 0, ADD, 0, 0, 0, 1, 1), "to_halt");
    mem_ready = 1'b1;
    cyc(v(0, 0, 2'd0, 0, 0, ADD, 0, 0, 0, 1, 1), "to_stay");
    mem_ready = 1'b0;
    chk_ret("to_ret");
    do_reset("to_reset");

    // ecall-class opcode halts without retiring
    run_alu(32'h002081B3, ADD, 1'b0, "add2");
    front(32'h00000073);
    cyc(v(0, 0, 2'd0, 0, 0, ADD, 0, 0, 0, 1, 0), "ecall_halt");
    chk_ret("ecall_ret");
    do_reset("ecall_reset");

    // reset landing in the middle of a load's MEM wait
    run_alu(32'h402081B3, SUB, 1'b0, "sub2");
    front(32'h0000A103);
    cyc(v(0, 0, 2'd0, 0, 1, ADD, 0, 0, 0, 0, 0), "lw2_exec");
    cyc(v(0, 0, 2'd0, 0, 1, ADD, 1, 0, 0, 0, 0), "lw2_mem");
    do_reset("mid_reset");
    run_alu(32'h0020A1B3, SLT, 1'b0, "slt_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
